// File: rtl/neuron_mac_accumulator_if.sv
// Handshake bundle between the upstream x/w streamer, the MAC accumulator and
// the downstream sigmoid stage. The accumulator itself uses the slave view.
interface neuron_mac_accumulator_if #(
   parameter int DWIDTH = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DWIDTH-1:0] x;
   logic [DWIDTH-1:0] w;
   logic [DWIDTH-1:0] bias;
   logic              out_valid;
   logic              out_ready;
   logic [DWIDTH-1:0] out_data;

   modport master (
      output in_valid, x, w, bias, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, x, w, bias, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/neuron_mac_accumulator.sv
// One neuron's pre-activation sum: sum(x*w) + bias over IWIDTH streamed pairs.
// Products are kept at full precision; rounding (floor) and saturation are
// applied once when the result is registered.
module neuron_mac_accumulator #(
   parameter int DWIDTH = 16,
   parameter int FRAC   = 12,
   parameter int IWIDTH = 64
) (
   input logic                        clk,
   input logic                        rst_n,
   neuron_mac_accumulator_if.slave    bus
);

   localparam int AW = 2 * DWIDTH + $clog2(IWIDTH) + 1;
   localparam int PW = 2 * DWIDTH;
   localparam int CW = $clog2(IWIDTH + 1);

   // Saturation bounds, expressed at the width of the shifted sum.
   localparam logic signed [AW:0] SAT_MAX = {{(AW + 2 - DWIDTH){1'b0}}, {(DWIDTH - 1){1'b1}}};
   localparam logic signed [AW:0] SAT_MIN = {{(AW + 2 - DWIDTH){1'b1}}, {(DWIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {ACC, FLUSH, FINAL, OUT} state_t;

   state_t                   state_reg, state_next;
   logic signed [PW-1:0]     p_reg;
   logic                     p_vld_reg;
   logic signed [AW-1:0]     acc_reg;
   logic [CW-1:0]            count_reg;
   logic [DWIDTH-1:0]        bias_reg;
   logic [DWIDTH-1:0]        out_data_reg;
   logic                     out_valid_reg;

   logic                     in_ready_next;
   logic                     accept;
   logic                     out_fire;
   logic                     last_pair;
   logic signed [PW-1:0]     product;
   logic signed [AW:0]       bias_ext;
   logic signed [AW:0]       sum_full;
   logic signed [AW:0]       trunc;
   logic [DWIDTH-1:0]        sat_data;

   assign accept    = bus.in_valid && in_ready_next;
   assign out_fire  = out_valid_reg && bus.out_ready;
   assign last_pair = (count_reg == CW'(IWIDTH - 1));
   assign product   = $signed(bus.x) * $signed(bus.w);

   assign bus.in_ready  = in_ready_next;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_data  = out_data_reg;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ACC;
      else        state_reg <= state_next;
   end

   // Next-state logic; pairs are only taken while accumulating.
   always_comb begin
      state_next    = state_reg;
      in_ready_next = 1'b0;
      case (state_reg)
         ACC: begin
            in_ready_next = 1'b1;
            if (bus.in_valid && last_pair) state_next = FLUSH;
         end
         FLUSH:   state_next = FINAL;
         FINAL:   state_next = OUT;
         OUT:     if (out_valid_reg && bus.out_ready) state_next = ACC;
         default: state_next = ACC;
      endcase
   end

   // Bias alignment to the product scale, sum, floor shift and clamp.
   always_comb begin
      bias_ext = {{(AW + 1 - DWIDTH){bias_reg[DWIDTH-1]}}, bias_reg};
      sum_full = $signed({acc_reg[AW-1], acc_reg}) + (bias_ext <<< FRAC);
      trunc    = sum_full >>> FRAC;
      if (trunc > SAT_MAX)      sat_data = SAT_MAX[DWIDTH-1:0];
      else if (trunc < SAT_MIN) sat_data = SAT_MIN[DWIDTH-1:0];
      else                      sat_data = trunc[DWIDTH-1:0];
   end

   // Product stage, accumulator, term counter and bias capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_reg     <= '0;
         p_vld_reg <= 1'b0;
         acc_reg   <= '0;
         count_reg <= '0;
         bias_reg  <= '0;
      end else begin
         if (accept) p_reg <= product;
         p_vld_reg <= accept && !out_fire;

         if (out_fire)
            acc_reg <= '0;
         else if (p_vld_reg)
            acc_reg <= acc_reg + {{(AW - PW){p_reg[PW-1]}}, p_reg};

         if (out_fire)    count_reg <= '0;
         else if (accept) count_reg <= count_reg + 1'b1;

         if (accept && count_reg == '0) bias_reg <= bus.bias;
      end
   end

   // Result register: loaded once per neuron, held until the consumer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
      end else if (state_reg == FINAL) begin
         out_data_reg  <= sat_data;
         out_valid_reg <= 1'b1;
      end else if (out_fire) begin
         out_valid_reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Directed bench for neuron_mac_accumulator at IWIDTH = 4, Q3.12.
module tb_neuron_mac_accumulator;

   localparam int DWIDTH = 16;
   localparam int FRAC   = 12;
   localparam int IWIDTH = 4;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   neuron_mac_accumulator_if #(.DWIDTH(DWIDTH)) bus ();

   neuron_mac_accumulator #(
      .DWIDTH (DWIDTH),
      .FRAC   (FRAC),
      .IWIDTH (IWIDTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive pairs following a valid pattern (msb first); bias is only the
   // requested value on the first pair, garbage afterwards.
   task automatic send_seq(input string tag, input logic [15:0] xv, input logic [15:0] wv,
                           input logic [15:0] bv, input logic [15:0] pat, input int len);
      int taken;
      taken = 0;
      for (int i = len - 1; i >= 0; i--) begin
         check_val({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
         bus.in_valid = pat[i];
         bus.x        = xv;
         bus.w        = wv;
         bus.bias     = (taken == 0) ? bv : 16'h7777;
         @(posedge clk);
         #1;
         if (pat[i]) taken++;
      end
      bus.in_valid = 1'b0;
      bus.x        = 16'h0;
      bus.w        = 16'h0;
      check_val({tag, "_in_ready_low"}, {31'd0, bus.in_ready}, 32'd0);
   endtask

   // Called 1 ns after the last accepting edge. Checks latency and data,
   // optionally stalls the consumer, then completes the output handshake.
   task automatic take_result(input string tag, input logic [15:0] exp, input int stall);
      int cycles;
      cycles = 0;
      while (!bus.out_valid && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      check_val({tag, "_latency"}, cycles, 32'd2);
      check_val({tag, "_data"}, {16'd0, bus.out_data}, {16'd0, exp});
      for (int k = 0; k < stall; k++) begin
         bus.in_valid = 1'b1;
         bus.x        = 16'($urandom);
         bus.w        = 16'($urandom);
         bus.bias     = 16'($urandom);
         @(posedge clk);
         #1;
         check_val({tag, "_stall_valid"}, {31'd0, bus.out_valid}, 32'd1);
         check_val({tag, "_stall_data"}, {16'd0, bus.out_data}, {16'd0, exp});
         check_val({tag, "_stall_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check_val({tag, "_valid_cleared"}, {31'd0, bus.out_valid}, 32'd0);
      check_val({tag, "_in_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
      check_val({tag, "_data_held"}, {16'd0, bus.out_data}, {16'd0, exp});
      $display("neuron %s: out_data=%h expected=%h latency=%0d", tag, bus.out_data, exp, cycles);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.x         = 16'h0;
      bus.w         = 16'h0;
      bus.bias      = 16'h0;
      bus.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_val("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check_val("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check_val("reset_out_data", {16'd0, bus.out_data}, 32'd0);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 4 x (1.0 * 0.5) + 0.25 = 2.25
      send_seq("basic", 16'h1000, 16'h0800, 16'h0400, 16'hF, 4);
      take_result("basic", 16'h2400, 0);

      send_seq("pos_sat", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hF, 4);
      take_result("pos_sat", 16'h7FFF, 0);

      send_seq("neg_sat", 16'h7FFF, 16'h8000, 16'h0000, 16'hF, 4);
      take_result("neg_sat", 16'h8000, 0);

      // 4 x (1.0 * -1.0) = -4.0
      send_seq("neg", 16'h1000, 16'hF000, 16'h0000, 16'hF, 4);
      take_result("neg", 16'hC000, 0);

      // Sum of products is -4 at 2^-24 scale; floor to 2^-12 gives -1 LSB.
      send_seq("trunc", 16'h0001, 16'hFFFF, 16'h0000, 16'hF, 4);
      take_result("trunc", 16'hFFFF, 0);

      send_seq("bp", 16'h1000, 16'h0800, 16'h0400, 16'hF, 4);
      take_result("bp", 16'h2400, 6);

      send_seq("after_bp", 16'h1000, 16'hF000, 16'h0000, 16'hF, 4);
      take_result("after_bp", 16'hC000, 0);

      // Pattern 1,0,0,1,1,0,1 with bias garbage after the first pair.
      send_seq("bubbles", 16'h1000, 16'h0800, 16'h0400, 16'b1001101, 7);
      take_result("bubbles", 16'h2400, 0);

      // Two pairs of a neuron, then reset asynchronously between edges.
      bus.in_valid = 1'b1;
      bus.x        = 16'h7FFF;
      bus.w        = 16'h7FFF;
      bus.bias     = 16'h7FFF;
      repeat (2) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      #2;
      check_val("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check_val("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check_val("rst_mid_out_data", {16'd0, bus.out_data}, 32'd0);
      @(posedge clk);
      #1;
      check_val("rst_hold_out_data", {16'd0, bus.out_data}, 32'd0);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_seq("after_rst", 16'h1000, 16'h0800, 16'h0400, 16'hF, 4);
      take_result("after_rst", 16'h2400, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/neuron_mac_accumulator.md
# neuron_mac_accumulator

Sequential multiply-accumulate stage that forms one neuron's pre-activation sum, Σ(x·w) + bias, over IWIDTH input/weight pairs, streamed one per cycle. It sits directly upstream of the sigmoid activation stage and delivers a saturated signed DWIDTH fixed-point result through a valid/ready handshake. Full-precision products are accumulated internally. Rounding and saturation happen only once, at the output.

## Interface
- DWIDTH, 16: data width of x, w, bias and out_data; signed two's complement.
- FRAC, 12: fractional bits of the fixed-point format (Q3.12 at default).
- IWIDTH, 64: number of x·w terms per neuron; must be ≥ 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; fixed polarity and synchronicity.
- in_valid  input  1  x/w pair present.
- in_ready  output  1  block accepts a pair; high exactly in state ACC.
- x  input  DWIDTH  signed activation input.
- w  input  DWIDTH  signed weight.
- bias  input  DWIDTH  signed bias; sampled with the first accepted pair of each neuron.
- out_valid  output  1  result available; held until accepted.
- out_ready  input  1  consumer (sigmoid stage) accepts result.
- out_data  output  DWIDTH  saturated signed result, same Q format as x.

## Operation
- Internal accumulator width: AW = 2·DWIDTH + clog2(IWIDTH) + 1. It cannot overflow.
- States and transitions:
  - ACC → FLUSH when the IWIDTH-th pair is accepted.
  - FLUSH → FINAL unconditionally.
  - FINAL → OUT unconditionally.
  - OUT → ACC on out_valid && out_ready.
- Acceptance: a pair is accepted at an edge where in_valid && in_ready. in_valid is ignored in every other state.
- Product pipeline: an accepted pair loads p_reg = x·w, a signed 2·DWIDTH product. p_vld is set the same edge.
- Accumulation: acc += sign-extended p_reg at each edge where p_vld = 1.
- Counter: term counter 0..IWIDTH increments per accepted pair. Gaps in in_valid are allowed; they only stall the count.
- Bias: latched at the edge accepting the pair with counter = 0.
- Result, computed at the FINAL edge: s = acc + (bias <<< FRAC), then t = s >>> FRAC (arithmetic shift, truncation toward −∞).
  - out_data = 2^(DWIDTH−1)−1 if t exceeds it.
  - out_data = −2^(DWIDTH−1) if t is below it.
  - out_data = t[DWIDTH−1:0] otherwise.
- Output acceptance clears acc, counter, p_vld and out_valid. in_ready is high the following cycle.
- out_data holds its last value after acceptance; it is not cleared.
- Reset values: state ACC, in_ready 1, out_valid 0, out_data 0, acc 0, counter 0, p_vld 0, bias register 0.

## Timing
- Latency: the last pair is accepted at edge E0.
  - E1: acc includes the last product.
  - E2: out_data is registered and out_valid = 1.
  - out_valid is therefore visible in the cycle after E2.
- Throughput at IWIDTH = N with out_ready tied high: one result per N + 3 cycles. The output handshake cycle is counted.
- out_valid, once high, stays high with out_data stable until the out_ready edge. Stalling is unbounded.
- in_ready is low from the edge after the last acceptance until the edge after output acceptance.
- Reset asserted mid-operation: all registers return to reset values immediately, with no clock required.
  - Partial sums are discarded.
  - The first pair accepted after release starts a new neuron.
- rst_n deassertion must meet recovery time to clk. No pair is accepted in the cycle rst_n is low.

## Test plan
All scenarios use IWIDTH = 4 and FRAC = 12.
- Basic: 4 × (x = 0x1000, w = 0x0800), bias = 0x0400 → out_data = 0x2400 (2.25); out_valid rises 2 edges after the 4th acceptance.
- Positive saturation: 4 × (0x7FFF, 0x7FFF), bias = 0x7FFF → out_data = 0x7FFF. Negative: 4 × (0x7FFF, 0x8000) → 0x8000.
- Negative and truncation:
  - 4 × (0x1000, 0xF000), bias = 0 → 0xC000 (−4.0).
  - 4 × (0x0001, 0xFFFF), bias = 0 → 0xFFFF (−4 LSB product sum, floor gives −1).
- Backpressure: hold out_ready low 6 cycles after out_valid while driving in_valid = 1 with garbage → out_valid and out_data stable, in_ready = 0, no pairs counted. The next neuron's result is correct.
- Bubbles: in_valid toggling 1,0,0,1,1,0,1 for the basic vectors → same 0x2400. Bias changed after the first acceptance has no effect.
- Reset mid-neuron: assert rst_n after 2 pairs, release, run the basic vectors → 0x2400. All outputs read reset values while rst_n = 0.
